ie_stack_seq: RTL and testbench
===============================

// Module: ie_stack_seq
// PURPOSE
//  Parametrised stack push/pull sequencer for the CPU execute stage; generalises single-byte push/pull to N-byte transfers.
//  Serialises a multi-byte word (PCH/PCL/P etc.) to/from the stack page over the CPU memory bus, owns the stack pointer.
//  Sits between execute/interrupt FSMs (requesters) and the memory bus mux; one transfer in flight at a time.
// PARAMETERS
//  MAX_BYTES   3      max bytes per transfer (1..4)
//  STACK_PAGE  8'h01  high address byte of stack page
//  READ_LAT    2      cycles from mem_read_en/addr issue to mem_data_in valid (1..4)
//  SP_RESET    8'hFF  stack pointer value after reset
// PORTS
//  clk           in   1              clock, all logic on rising edge
//  rst           in   1              synchronous, active-low reset
//  req_valid     in   1              transfer request
//  req_ready     out  1              =1 in IDLE and sp_load low; accept = req_valid & req_ready
//  req_push      in   1              1 = push, 0 = pull
//  req_len       in   3              byte count 0..MAX_BYTES (larger values clamp to MAX_BYTES)
//  req_data      in   8*MAX_BYTES    push data, byte k = req_data[8k+:8]
//  rsp_data      out  8*MAX_BYTES    pull result, same packing; bytes >= len zeroed
//  done          out  1              one-cycle pulse at end of transfer
//  busy          out  1              =1 from cycle after accept until done cycle inclusive
//  sp_load       in   1              overwrite stack pointer (honoured only in IDLE)
//  sp_load_val   in   8              value for sp_load
//  sp            out  8              current stack pointer
//  mem_addr      out  16             bus address
//  mem_data_out  out  8              bus write data
//  mem_write_en  out  1              write strobe, one cycle per byte
//  mem_read_en   out  1              read strobe, one cycle per byte
//  mem_data_in   in   8              bus read data
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, sp=SP_RESET, mem_addr=0, mem_data_out=0, strobes 0, done 0, busy 0, rsp_data 0.
//  Reset mid-transfer aborts immediately; no further strobes; sp takes SP_RESET (partial sp changes discarded).
//  States: IDLE -> PUSH | PULL_ISSUE -> PULL_WAIT -> ... -> FINISH -> IDLE.
//  Accept at cycle T0 latches push/len/data; len=0 -> FINISH at T1 (done at T1), no bus activity, sp unchanged.
//  Push: byte order high-first (k=len-1 down to 0). Cycle T1+i: mem_addr={STACK_PAGE,sp}, data=byte, write_en=1, sp<=sp-1.
//   Last write at T_len; done pulses T_len+1; req_ready high again at T_len+1.
//  Pull: byte order low-first (k=0 up). Issue cycle Ti=T1+i*(READ_LAT+1): mem_addr={STACK_PAGE,sp+1}, read_en=1, sp<=sp+1.
//   mem_data_in sampled at Ti+READ_LAT into rsp_data byte i; done at cycle after last sample; rsp_data stable until next pull accept.
//  Push then pull of same len restores sp and returns identical rsp_data.
//  sp arithmetic 8-bit modulo: push at 00 -> FF, pull at FF -> 00; address always stays in STACK_PAGE.
//  sp_load & req_valid same IDLE cycle: sp_load wins, req_ready=0, request waits. sp_load while busy: ignored.
//  Strobes low in every non-issue cycle; mem_addr/mem_data_out hold last value when idle.
// CONFIGURATION
//  Macro STACK_WRAP_DETECT_EN:
//   defined: extra port stack_err out 1, sticky; set on any push byte issued at sp=00 or pull byte issued at sp=FF;
//    cleared by reset or sp_load; transfer still completes with wrap.
//   undefined: no stack_err port; wrap is silent.
// TESTING
//  Reset: drive rst=0 one edge -> sp=FF, strobes 0, busy 0, req_ready 1.
//  Push len=3, data=24'h12_34_A5, sp=FF -> writes 01FF=12, 01FE=34, 01FD=A5 at T1..T3, done T4, sp=FC.
//  Pull len=3 from sp=FC, READ_LAT=2 -> reads 01FD,01FE,01FF at T1,T4,T7, rsp_data=24'h1234A5, done T10, sp=FF.
//  len=0 push and pull -> done at T1, no strobes, sp unchanged; len=7 -> treated as 3.
//  sp_load=1 val=00 with req_valid same cycle -> sp=00, request accepted next cycle; push 1 -> write 0100, sp=FF, stack_err=1 (macro on).
//  rst low at T2 of 3-byte push -> no write at T3, sp=FF, done never pulses.

Source files
------------

// File: rtl/ie_stack_seq.sv
// Stack push/pull sequencer: moves up to MAX_BYTES bytes to/from the stack page and owns sp.
// Latency: push len+1 cycles, pull len*(READ_LAT+1)+1 cycles to done; req_ready low while a transfer runs or sp_load is high.
// `STACK_WRAP_DETECT_EN adds a sticky stack_err output that flags sp wrap-around.
module ie_stack_seq #(
   parameter int         MAX_BYTES  = 3,
   parameter logic [7:0] STACK_PAGE = 8'h01,
   parameter int         READ_LAT   = 2,
   parameter logic [7:0] SP_RESET   = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_push,
   input  logic [2:0]             req_len,
   input  logic [8*MAX_BYTES-1:0] req_data,
   output logic [8*MAX_BYTES-1:0] rsp_data,
   output logic                   done,
   output logic                   busy,
   input  logic                   sp_load,
   input  logic [7:0]             sp_load_val,
   output logic [7:0]             sp,
   output logic [15:0]            mem_addr,
   output logic [7:0]             mem_data_out,
   output logic                   mem_write_en,
   output logic                   mem_read_en,
`ifdef STACK_WRAP_DETECT_EN
   output logic                   stack_err,
`endif
   input  logic [7:0]             mem_data_in
);
   localparam int         DW        = 8*MAX_BYTES;
   localparam logic [2:0] MAX_LEN   = 3'(MAX_BYTES);
   localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

   typedef enum logic [2:0] {IDLE, PUSH, PULL_ISSUE, PULL_WAIT, FINISH} state_t;

   state_t        state;
   logic [2:0]    len_r;
   logic [2:0]    idx;
   logic [2:0]    wcnt;
   logic [DW-1:0] data_r;
   logic [2:0]    len_c;
   logic          accept;

   assign len_c     = (req_len > MAX_LEN) ? MAX_LEN : req_len;
   // FINISH counts as idle for new requests so back-to-back transfers lose no cycle.
   assign req_ready = ((state == IDLE) || (state == FINISH)) && !sp_load;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         sp           <= SP_RESET;
         mem_addr     <= '0;
         mem_data_out <= '0;
         mem_write_en <= 1'b0;
         mem_read_en  <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
         rsp_data     <= '0;
         len_r        <= '0;
         idx          <= '0;
         wcnt         <= '0;
         data_r       <= '0;
      end else begin
         mem_write_en <= 1'b0;
         mem_read_en  <= 1'b0;
         done         <= 1'b0;
         case (state)
            IDLE, FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               if ((state == IDLE) && sp_load) begin
                  sp <= sp_load_val;
               end else if (accept) begin
                  busy   <= 1'b1;
                  len_r  <= len_c;
                  data_r <= req_data;
                  if (!req_push)
                     rsp_data <= '0;
                  // Bus outputs are registered, so the first byte is launched here.
                  if (len_c == 3'd0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else if (req_push) begin
                     state        <= PUSH;
                     idx          <= len_c - 3'd1;
                     mem_addr     <= {STACK_PAGE, sp};
                     mem_data_out <= 8'(req_data >> {len_c - 3'd1, 3'b000});
                     mem_write_en <= 1'b1;
                  end else begin
                     state       <= PULL_ISSUE;
                     idx         <= 3'd0;
                     mem_addr    <= {STACK_PAGE, sp + 8'd1};
                     mem_read_en <= 1'b1;
                  end
               end
            end
            PUSH: begin
               sp <= sp - 8'd1;
               if (idx == 3'd0) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end else begin
                  idx          <= idx - 3'd1;
                  mem_addr     <= {STACK_PAGE, sp - 8'd1};
                  mem_data_out <= 8'(data_r >> {idx - 3'd1, 3'b000});
                  mem_write_en <= 1'b1;
               end
            end
            PULL_ISSUE: begin
               sp    <= sp + 8'd1;
               wcnt  <= 3'd0;
               state <= PULL_WAIT;
            end
            PULL_WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  rsp_data <= rsp_data | (DW'(mem_data_in) << {idx, 3'b000});
                  if (idx == len_r - 3'd1) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     idx         <= idx + 3'd1;
                     mem_addr    <= {STACK_PAGE, sp + 8'd1};
                     mem_read_en <= 1'b1;
                     state       <= PULL_ISSUE;
                  end
               end else begin
                  wcnt <= wcnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STACK_WRAP_DETECT_EN
   always_ff @(posedge clk) begin
      if (!rst)
         stack_err <= 1'b0;
      else if ((state == IDLE) && sp_load)
         stack_err <= 1'b0;
      else if (((state == PUSH) && (sp == 8'h00)) || ((state == PULL_ISSUE) && (sp == 8'hFF)))
         stack_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ie_stack_seq.sv
// Bench for ie_stack_seq: directed cases, then random transfers against a byte-level stack model.
module tb_ie_stack_seq;
   localparam int MB = 3;
   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_push, done, busy, sp_load;
   logic        mem_write_en, mem_read_en;
   logic [2:0]  req_len;
   logic [23:0] req_data, rsp_data;
   logic [7:0]  sp_load_val, sp, mem_data_out, mem_data_in;
   logic [15:0] mem_addr;
`ifdef STACK_WRAP_DETECT_EN
   logic        stack_err;
`endif

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [7:0]  ram [256];
   logic [7:0]  ref_stack [256];
   logic [7:0]  ref_sp;
   logic [23:0] ref_rsp;
   bit          sched_vld [8];
   logic [7:0]  sched_addr [8];
   logic [2:0]  rnd_len;
   bit          rnd_push;

   always #5 clk = ~clk;

   ie_stack_seq #(.MAX_BYTES(MB), .STACK_PAGE(8'h01), .READ_LAT(RL), .SP_RESET(8'hFF)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push),
      .req_len(req_len), .req_data(req_data), .rsp_data(rsp_data), .done(done), .busy(busy),
      .sp_load(sp_load), .sp_load_val(sp_load_val), .sp(sp), .mem_addr(mem_addr),
      .mem_data_out(mem_data_out), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
`ifdef STACK_WRAP_DETECT_EN
      .stack_err(stack_err),
`endif
      .mem_data_in(mem_data_in));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; act as the stack-page memory with READ_LAT read latency.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_write_en === 1'b1)
         ram[mem_addr[7:0]] = mem_data_out;
      if (sched_vld[cyc % 8]) begin
         mem_data_in = ram[sched_addr[cyc % 8]];
         sched_vld[cyc % 8] = 1'b0;
      end else begin
         mem_data_in = 8'($urandom);
      end
      if (mem_read_en === 1'b1) begin
         sched_vld[(cyc + RL) % 8]  = 1'b1;
         sched_addr[(cyc + RL) % 8] = mem_addr[7:0];
      end
   endtask

   task automatic load_sp(input logic [7:0] v);
      sp_load = 1'b1;
      sp_load_val = v;
      tick();
      sp_load = 1'b0;
      ref_sp = v;
      chk("sp_load", sp, v);
   endtask

   task automatic xfer(input bit push, input logic [2:0] len, input logic [23:0] data, input bit poke);
      int         n;
      int         done_at;
      logic [7:0] sp0;
      logic [7:0] bytes [3];
      bit         we, re;
      n = (len > 3'd3) ? 3 : int'(len);
      sp0 = ref_sp;
      for (int k = 0; k < 3; k++) bytes[k] = data[8*k +: 8];
      done_at = (n == 0) ? 1 : (push ? n + 1 : n * (RL + 1) + 1);
      req_valid = 1'b1;
      req_push = push;
      req_len = len;
      req_data = data;
      #1;
      chk("req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      req_data = 24'($urandom);
      req_len = 3'($urandom);
      req_push = 1'($urandom);
      if (poke && n > 0) begin
         sp_load = 1'b1;
         sp_load_val = 8'($urandom);
      end
      for (int c = 1; c <= done_at; c++) begin
         we = push && (c <= n);
         re = !push && ((c - 1) % (RL + 1) == 0) && ((c - 1) / (RL + 1) < n);
         chk($sformatf("ctl c%0d", c), {mem_write_en, mem_read_en, done, busy}, {we, re, c == done_at, 1'b1});
         if (we) begin
            chk("push addr", mem_addr, {8'h01, 8'(sp0 - 8'(c - 1))});
            chk("push data", mem_data_out, bytes[n - c]);
         end
         if (re)
            chk("pull addr", mem_addr, {8'h01, 8'(sp0 + 8'(1 + (c - 1) / (RL + 1)))});
         if (c < done_at) tick();
         sp_load = 1'b0;
      end
      if (push) begin
         for (int k = n - 1; k >= 0; k--) begin
            ref_stack[ref_sp] = bytes[k];
            ref_sp--;
         end
      end else begin
         ref_rsp = '0;
         for (int i = 0; i < n; i++) begin
            ref_sp++;
            ref_rsp[8*i +: 8] = ref_stack[ref_sp];
         end
      end
      #1;
      chk("sp at done", sp, ref_sp);
      chk("rsp_data", rsp_data, ref_rsp);
      chk("ready at done", req_ready, 1);
      tick();
      chk("idle after done", {done, busy, mem_write_en, mem_read_en}, 0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         ram[a] = 8'($urandom);
         ref_stack[a] = ram[a];
      end
      for (int s = 0; s < 8; s++) sched_vld[s] = 1'b0;
      rst = 1'b0; req_valid = 1'b0; req_push = 1'b0; req_len = 3'd0; req_data = '0;
      sp_load = 1'b0; sp_load_val = 8'h00; mem_data_in = 8'h00;
      ref_sp = 8'hFF; ref_rsp = '0;

      tick();
      tick();
      chk("reset sp", sp, 8'hFF);
      chk("reset ctl", {mem_write_en, mem_read_en, done, busy}, 0);
      chk("reset ready", req_ready, 1);
      chk("reset rsp", rsp_data, 0);
      chk("reset addr/data", {mem_addr, mem_data_out}, 0);
      rst = 1'b1;
      tick();

      xfer(1'b1, 3'd3, 24'h1234A5, 1'b0);
      chk("push3 sp", sp, 8'hFC);
      xfer(1'b0, 3'd3, 24'h000000, 1'b0);
      chk("pull3 rsp", rsp_data, 24'h1234A5);
      chk("pull3 sp", sp, 8'hFF);

      xfer(1'b1, 3'd0, 24'hABCDEF, 1'b0);
      xfer(1'b0, 3'd0, 24'h000000, 1'b0);
      xfer(1'b1, 3'd7, 24'h9A8B7C, 1'b0);
      xfer(1'b0, 3'd7, 24'h000000, 1'b0);
      chk("clamp rsp", rsp_data, 24'h9A8B7C);

      sp_load = 1'b1; sp_load_val = 8'h00;
      req_valid = 1'b1; req_push = 1'b1; req_len = 3'd1; req_data = 24'h00005A;
      #1;
      chk("ready blocked by sp_load", req_ready, 0);
      tick();
      sp_load = 1'b0;
      ref_sp = 8'h00;
      chk("sp_load wins", sp, 8'h00);
      chk("request held off", busy, 0);
      xfer(1'b1, 3'd1, 24'h00005A, 1'b0);
      chk("wrap push sp", sp, 8'hFF);
      chk("wrap push ram", ram[8'h00], 8'h5A);
`ifdef STACK_WRAP_DETECT_EN
      chk("stack_err set", stack_err, 1);
      load_sp(8'h80);
      chk("stack_err cleared", stack_err, 0);
`endif

      load_sp(8'h20);
      xfer(1'b1, 3'd2, 24'h00BEEF, 1'b1);
      xfer(1'b0, 3'd2, 24'h000000, 1'b1);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: load_sp(8'h00);
               1: load_sp(8'h01);
               2: load_sp(8'hFE);
               default: load_sp(8'($urandom));
            endcase
         end
         rnd_len = 3'($urandom);
         rnd_push = 1'($urandom);
         xfer(rnd_push, rnd_len, 24'($urandom), $urandom_range(0, 4) == 0);
      end

      load_sp(8'h40);
      req_valid = 1'b1; req_push = 1'b1; req_len = 3'd3; req_data = 24'hCAFE01;
      tick();
      req_valid = 1'b0;
      chk("abort T1 write", mem_write_en, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("abort ctl", {mem_write_en, mem_read_en, busy, done}, 0);
      chk("abort sp", sp, 8'hFF);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no done after abort", {done, busy, mem_write_en}, 0);
      end
      chk("ready after abort", req_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
